// File: rtl/video_pattern_stream.sv
// Parametrised video timing generator with selectable test patterns.
// Counter state is decoded combinationally and every output is registered one clock later.
module video_pattern_stream #(
    parameter int H_SYNC   = 40,
    parameter int H_BACK   = 220,
    parameter int H_DISP   = 1280,
    parameter int H_FRONT  = 110,
    parameter int V_SYNC   = 5,
    parameter int V_BACK   = 20,
    parameter int V_DISP   = 720,
    parameter int V_FRONT  = 5,
    parameter int CH_NUM   = 3,
    parameter int DW       = 8,
    parameter int SYNC_POL = 1,
    parameter int CHK_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 continuous,
    input  logic [1:0]           mode,
    input  logic [CH_NUM*DW-1:0] solid_color,
    output logic                 vout_vsync,
    output logic                 vout_hsync,
    output logic                 vout_valid,
    output logic [CH_NUM*DW-1:0] vout_dat,
    output logic                 vout_sof,
    output logic                 vout_eol,
    output logic                 vout_busy,
    output logic                 vout_done,
    output logic [15:0]          frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int PW      = CH_NUM * DW;
    localparam int H_ACT   = H_SYNC + H_BACK;
    localparam int V_ACT   = V_SYNC + V_BACK;
    localparam int BAR_W   = H_DISP / 8;

    localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
    localparam logic           IDLE_LVL = (SYNC_POL == 0);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t         state, state_nxt;
    logic [HCW-1:0] col, col_nxt;
    logic [VCW-1:0] row, row_nxt;
    logic           stop_req, stop_req_nxt;
    logic           start_d;
    logic [1:0]     mode_q;
    logic [PW-1:0]  solid_q;

    logic           frame_end;
    logic           at_origin;
    logic [1:0]     cur_mode;
    logic [PW-1:0]  cur_solid;

    assign frame_end = (state == S_RUN) && (col == H_LAST) && (row == V_LAST);
    assign at_origin = (state == S_RUN) && (col == '0) && (row == '0);
    // The frame's pattern is sampled at its first counter position so that mid-frame edits wait a frame.
    assign cur_mode  = at_origin ? mode : mode_q;
    assign cur_solid = at_origin ? solid_color : solid_q;

    // NOTE: async reset in the sensitivity list, and non-blocking (<=) for every registered signal so
    // all flops update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            col      <= '0;
            row      <= '0;
            stop_req <= 1'b0;
            start_d  <= 1'b0;
            mode_q   <= '0;
            solid_q  <= '0;
        end else begin
            state    <= state_nxt;
            col      <= col_nxt;
            row      <= row_nxt;
            stop_req <= stop_req_nxt;
            start_d  <= start;
            if (at_origin) begin
                mode_q  <= mode;
                solid_q <= solid_color;
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        col_nxt      = col;
        row_nxt      = row;
        stop_req_nxt = stop_req;
        case (state)
            S_IDLE: begin
                stop_req_nxt = 1'b0;
                if (start && !start_d) begin
                    state_nxt = S_RUN;
                    col_nxt   = '0;
                    row_nxt   = '0;
                end
            end
            S_RUN: begin
                if (stop) stop_req_nxt = 1'b1;
                if (col == H_LAST) begin
                    col_nxt = '0;
                    row_nxt = (row == V_LAST) ? '0 : row + 1'b1;
                end else begin
                    col_nxt = col + 1'b1;
                end
                if (frame_end && (!continuous || stop_req || stop)) begin
                    state_nxt    = S_IDLE;
                    stop_req_nxt = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    int            x, y, bar;
    logic          hs_act, vs_act, vis;
    logic [2:0]    code;
    logic [PW-1:0] pix;

    always_comb begin
        x      = int'(col) - H_ACT;
        y      = int'(row) - V_ACT;
        hs_act = int'(col) < H_SYNC;
        vs_act = int'(row) < V_SYNC;
        vis    = (x >= 0) && (x < H_DISP) && (y >= 0) && (y < V_DISP);
        bar    = 0;
        for (int k = 1; k < 8; k++) begin
            if (x >= k * BAR_W) bar = k;
        end
        code = 3'(7 - bar);
        pix  = '0;
        case (cur_mode)
            2'd0: for (int c = 0; c < CH_NUM; c++) pix[c*DW +: DW] = {DW{code[c % 3]}};
            2'd1: for (int c = 0; c < CH_NUM; c++) pix[c*DW +: DW] = x[DW-1:0];
            2'd2: pix = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? '0 : '1;
            default: pix = cur_solid;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vout_hsync <= IDLE_LVL;
            vout_vsync <= IDLE_LVL;
            vout_valid <= 1'b0;
            vout_dat   <= '0;
            vout_sof   <= 1'b0;
            vout_eol   <= 1'b0;
            vout_busy  <= 1'b0;
            vout_done  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            if (state == S_RUN) begin
                vout_hsync <= hs_act ^ IDLE_LVL;
                vout_vsync <= vs_act ^ IDLE_LVL;
                vout_valid <= vis;
                vout_dat   <= vis ? pix : '0;
                vout_sof   <= vis && (x == 0) && (y == 0);
                vout_eol   <= vis && (x == H_DISP - 1);
                vout_busy  <= 1'b1;
                vout_done  <= frame_end;
            end else begin
                vout_hsync <= IDLE_LVL;
                vout_vsync <= IDLE_LVL;
                vout_valid <= 1'b0;
                vout_dat   <= '0;
                vout_sof   <= 1'b0;
                vout_eol   <= 1'b0;
                vout_busy  <= 1'b0;
                vout_done  <= 1'b0;
            end
            if (frame_end) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_video_pattern_stream.sv
// Scoreboard bench: stimulus pushes expected per-clock records for each predicted frame,
// a negedge monitor pops them while the DUT is busy and checks idle outputs otherwise.
module tb_video_pattern_stream;

    localparam int HS = 2, HB = 2, HD = 16, HF = 2;
    localparam int VS = 1, VB = 1, VD = 4, VF = 1;
    localparam int CH = 3, W = 8, CHK = 2;
    localparam int HT = HS + HB + HD + HF;
    localparam int VT = VS + VB + VD + VF;
    localparam int FRAME = HT * VT;
    localparam int PW = CH * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, stop = 1'b0, continuous = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [PW-1:0] solid_color = '0;

    logic          vout_vsync, vout_hsync, vout_valid, vout_sof, vout_eol, vout_busy, vout_done;
    logic [PW-1:0] vout_dat;
    logic [15:0]   frame_cnt;
    logic          n_vsync, n_hsync, n_valid, n_sof, n_eol, n_busy, n_done;
    logic [PW-1:0] n_dat;
    logic [15:0]   n_frame_cnt;

    video_pattern_stream #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
        .CH_NUM(CH), .DW(W), .SYNC_POL(1), .CHK_LOG2(CHK)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .mode(mode), .solid_color(solid_color),
        .vout_vsync(vout_vsync), .vout_hsync(vout_hsync), .vout_valid(vout_valid),
        .vout_dat(vout_dat), .vout_sof(vout_sof), .vout_eol(vout_eol),
        .vout_busy(vout_busy), .vout_done(vout_done), .frame_cnt(frame_cnt)
    );

    video_pattern_stream #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
        .CH_NUM(CH), .DW(W), .SYNC_POL(0), .CHK_LOG2(CHK)
    ) dut_n (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .mode(mode), .solid_color(solid_color),
        .vout_vsync(n_vsync), .vout_hsync(n_hsync), .vout_valid(n_valid),
        .vout_dat(n_dat), .vout_sof(n_sof), .vout_eol(n_eol),
        .vout_busy(n_busy), .vout_done(n_done), .frame_cnt(n_frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          hs, vs, valid, sof, eol, done;
        logic [PW-1:0] dat;
    } rec_t;

    rec_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] model_pix(input int md, input logic [PW-1:0] sc,
                                                input int x, input int y);
        logic [PW-1:0] p;
        int bar, code;
        p = '0;
        case (md)
            0: begin
                bar = x / (HD / 8);
                if (bar > 7) bar = 7;
                code = 7 - bar;
                for (int c = 0; c < CH; c++) p[c*W +: W] = ((code >> (c % 3)) & 1) != 0 ? 8'hFF : 8'h00;
            end
            1: for (int c = 0; c < CH; c++) p[c*W +: W] = 8'(x % 256);
            2: p = (((x / (1 << CHK)) + (y / (1 << CHK))) % 2 == 0) ? '1 : '0;
            default: p = sc;
        endcase
        return p;
    endfunction

    task automatic push_frame(input int md, input logic [PW-1:0] sc);
        for (int k = 0; k < FRAME; k++) begin
            int col, row, x, y;
            rec_t r;
            col     = k % HT;
            row     = k / HT;
            x       = col - HS - HB;
            y       = row - VS - VB;
            r.hs    = col < HS;
            r.vs    = row < VS;
            r.valid = (x >= 0) && (x < HD) && (y >= 0) && (y < VD);
            r.dat   = r.valid ? model_pix(md, sc, x, y) : '0;
            r.sof   = r.valid && x == 0 && y == 0;
            r.eol   = r.valid && x == HD - 1;
            r.done  = (k == FRAME - 1);
            exp_q.push_back(r);
        end
    endtask

    always @(negedge clk) begin : monitor
        rec_t r;
        if (!rst) begin
            if (vout_busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_busy", 32'(vout_busy), 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    if (r.done) exp_frames = (exp_frames + 1) & 32'hFFFF;
                    check("hsync", 32'(vout_hsync), 32'(r.hs));
                    check("vsync", 32'(vout_vsync), 32'(r.vs));
                    check("valid", 32'(vout_valid), 32'(r.valid));
                    check("dat", 32'(vout_dat), 32'(r.dat));
                    check("sof", 32'(vout_sof), 32'(r.sof));
                    check("eol", 32'(vout_eol), 32'(r.eol));
                    check("done", 32'(vout_done), 32'(r.done));
                    check("n_hsync", 32'(n_hsync), 32'(!r.hs));
                    check("n_vsync", 32'(n_vsync), 32'(!r.vs));
                    check("n_valid", 32'(n_valid), 32'(r.valid));
                    check("n_dat", 32'(n_dat), 32'(r.dat));
                    check("n_busy", 32'(n_busy), 32'd1);
                end
            end else begin
                check("idle_hsync", 32'(vout_hsync), 32'd0);
                check("idle_vsync", 32'(vout_vsync), 32'd0);
                check("idle_valid", 32'(vout_valid), 32'd0);
                check("idle_dat", 32'(vout_dat), 32'd0);
                check("idle_flags", 32'({vout_sof, vout_eol, vout_done}), 32'd0);
                check("idle_n_sync", 32'({n_hsync, n_vsync}), 32'd3);
                check("idle_n_busy", 32'(n_busy), 32'd0);
            end
            check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
            check("n_frame_cnt", 32'(n_frame_cnt), 32'(exp_frames));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        tick(3);
    endtask

    task automatic check_inactive(input string tag);
        check({tag, "_valid"}, 32'(vout_valid), 32'd0);
        check({tag, "_busy"}, 32'(vout_busy), 32'd0);
        check({tag, "_done"}, 32'(vout_done), 32'd0);
        check({tag, "_dat"}, 32'(vout_dat), 32'd0);
        check({tag, "_syncs"}, 32'({vout_hsync, vout_vsync}), 32'd0);
        check({tag, "_n_syncs"}, 32'({n_hsync, n_vsync}), 32'd3);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        logic [PW-1:0] sc, sc2;
        int md;

        tick(3);
        check_inactive("reset");
        rst = 1'b0;
        tick(2);

        // Single frame of colour bars.
        mode = 2'd0;
        continuous = 1'b0;
        push_frame(0, solid_color);
        pulse_start();
        drain("single_frame", 4 * FRAME);
        tick(20);

        // Solid colour, exercised on both sync polarities.
        mode = 2'd3;
        solid_color = 24'h123456;
        push_frame(3, 24'h123456);
        pulse_start();
        drain("solid_frame", 4 * FRAME);

        for (int i = 0; i < 5; i++) begin
            md = int'($urandom_range(0, 3));
            sc = PW'($urandom);
            mode = 2'(md);
            solid_color = sc;
            push_frame(md, sc);
            tick(int'($urandom_range(0, 5)));
            pulse_start();
            drain("random_frame", 4 * FRAME);
        end

        // Continuous run: stop in IDLE is ignored, start edge during RUN is ignored,
        // solid colour edited mid frame 1 shows in frame 2, stop mid frame 2 ends after it.
        continuous = 1'b1;
        mode = 2'd3;
        sc  = PW'($urandom);
        sc2 = PW'($urandom);
        solid_color = sc;
        pulse_stop();
        tick(2);
        push_frame(3, sc);
        push_frame(3, sc2);
        pulse_start();
        tick(30);
        pulse_start();
        tick(9);
        solid_color = sc2;
        tick(FRAME - 40 + int'($urandom_range(5, 130)));
        pulse_stop();
        drain("stop_frames", 4 * FRAME);
        tick(200);

        // Mode changed 0 -> 2 mid frame takes effect on the next frame.
        mode = 2'd0;
        push_frame(0, solid_color);
        push_frame(2, solid_color);
        pulse_start();
        tick(60);
        mode = 2'd2;
        tick(FRAME - 61 + 40);
        pulse_stop();
        drain("mode_change", 4 * FRAME);

        // Reset at row 3 col 10 aborts at once; a fresh start gives a full frame.
        continuous = 1'b0;
        mode = 2'd1;
        push_frame(1, solid_color);
        pulse_start();
        tick(3 * HT + 10);
        rst = 1'b1;
        #1;
        check_inactive("midreset");
        exp_q.delete();
        exp_frames = 0;
        tick(2);
        rst = 1'b0;
        tick(2);
        push_frame(1, solid_color);
        pulse_start();
        drain("after_reset", 4 * FRAME);
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
